// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_seq_pkg: state encoding and counter sizing shared by the reset sequencer
package pll_reset_seq_pkg;
  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing the asynchronous lock flag into clk
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // two-stage capture, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q <= 1'b0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulsing, lock qualification and staged domain reset release
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STABLE_CYC   = 1024,
  parameter int N_DOM        = 4,
  parameter int STAGE_GAP    = 8,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked_i,
  output logic             pll_reset_o,
  output logic [N_DOM-1:0] dom_rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] lock_loss_cnt
);
  localparam int REL_CYC = STAGE_GAP * N_DOM;
  localparam int M1 = (LOCK_TIMEOUT > STABLE_CYC) ? LOCK_TIMEOUT : STABLE_CYC;
  localparam int M2 = (REL_CYC > PLL_RST_CYC) ? REL_CYC : PLL_RST_CYC;
  localparam int CW = cnt_width((M1 > M2) ? M1 : M2);
  localparam int RW = cnt_width(MAX_RETRY);
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry, retry_n;
  logic [N_DOM-1:0] dom_n;
  logic locked_s, loss;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d(pll_locked_i),
    .q(locked_s)
  );
  // next state, shared phase counter, retry tracking and next registered outputs
  always_comb begin
    st_n = st;
    cnt_n = cnt + 1'b1;
    retry_n = retry;
    loss = !locked_s && (st == S_RELEASE || st == S_RUN);
    case (st)
      S_PLL_RST: begin
        if (cnt == CW'(PLL_RST_CYC - 1)) begin
          st_n = S_WAIT_LOCK;
          cnt_n = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          st_n = S_STABLE;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_n = retry + 1'b1;
          st_n = (retry_n == RW'(MAX_RETRY)) ? S_FAIL : S_PLL_RST;
          cnt_n = '0;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          st_n = S_WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt == CW'(STABLE_CYC - 1)) begin
          st_n = S_RELEASE;
          cnt_n = '0;
          retry_n = '0;
        end
      end
      S_RELEASE: begin
        if (cnt == CW'(REL_CYC - 1)) begin
          st_n = S_RUN;
          cnt_n = '0;
        end
      end
      S_RUN: cnt_n = '0;
      S_FAIL: cnt_n = '0;
      default: begin
        st_n = S_PLL_RST;
        cnt_n = '0;
      end
    endcase
    if (loss) begin
      st_n = S_PLL_RST;
      cnt_n = '0;
    end
    for (int k = 0; k < N_DOM; k++)
      dom_n[k] = !(st_n == S_RUN || (st_n == S_RELEASE && int'(cnt_n) >= STAGE_GAP * k));
  end
  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_PLL_RST;
      cnt <= '0;
      retry <= '0;
      pll_reset_o <= 1'b1;
      dom_rst_o <= '1;
      ready_o <= 1'b0;
      fail_o <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      retry <= retry_n;
      pll_reset_o <= (st_n == S_PLL_RST);
      dom_rst_o <= dom_n;
      ready_o <= (st_n == S_RUN);
      fail_o <= (st_n == S_FAIL);
      lock_loss_cnt <= (loss && lock_loss_cnt != '1) ? lock_loss_cnt + 1'b1 : lock_loss_cnt;
    end
  end
endmodule
